// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM state type and size-to-byte-count helper for the byte-serial LSU.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;

    // Number of bytes moved for a size code: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extender: takes the low 1/2/4/8 bytes of a 64-bit accumulator to a full 64-bit value.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [63:0] acc_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [63:0] data_o
);

    // Select the live bytes and fill the upper bits with zero or the top live bit.
    always_comb begin
        data_o = acc_i;
        case (size_i)
            SZ_B:    data_o = unsigned_i ? {56'b0, acc_i[7:0]}  : {{56{acc_i[7]}},  acc_i[7:0]};
            SZ_H:    data_o = unsigned_i ? {48'b0, acc_i[15:0]} : {{48{acc_i[15]}}, acc_i[15:0]};
            SZ_W:    data_o = unsigned_i ? {32'b0, acc_i[31:0]} : {{32{acc_i[31]}}, acc_i[31:0]};
            default: data_o = acc_i;
        endcase
    end

endmodule

// File: rtl/byte_serial_lsu.sv
// Byte-serial load/store unit: one request per handshake, N bytes little-endian, one byte per cycle; LSU_MISALIGN_TRAP_EN rejects misaligned requests.
// Latency: accept at edge T, bytes in cycles T+1..T+N, resp_valid in T+N+1 (errors at T+1).
// Backpressure: req_ready only in IDLE; requests presented while busy are ignored, no queueing.
module byte_serial_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    lsu_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic              uns_q,   uns_d;
    logic              err_q,   err_d;
    logic [1:0]        size_q,  size_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       acc_q,   acc_d;
    logic [2:0]        cnt_q,   cnt_d;

    logic [3:0]        n_req;
    logic [3:0]        n_cur;
    logic [ADDR_W:0]   req_end;
    logic              range_bad;
    logic              misalign;
    logic              last_byte;
    logic [63:0]       ext_data;

    // Range check done one bit wider than the address so a top-of-space request cannot wrap into range.
    assign n_req     = size_bytes(req_size);
    assign req_end   = {1'b0, req_addr} + {{(ADDR_W-3){1'b0}}, n_req};
    assign range_bad = req_end > MEM_LIMIT;
    assign misalign  = (req_addr[2:0] & (n_req[2:0] - 3'd1)) != 3'd0;
    assign n_cur     = size_bytes(size_q);
    assign last_byte = {1'b0, cnt_q} == (n_cur - 4'd1);

    lsu_extend u_extend (
        .acc_i      (acc_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    // Next-state, request latch, byte sequencing and all outputs.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        uns_d      = uns_q;
        err_d      = err_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 64'd0;
        resp_err   = 1'b0;
        busy       = 1'b1;
        mem_addr   = '0;
        mem_wdata  = 8'd0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    acc_d   = 64'd0;
                    cnt_d   = 3'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_d   = range_bad | misalign;
`else
                    err_d   = range_bad;
`endif
                    state_d = err_d ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = addr_q + ADDR_W'(cnt_q);
                if (write_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
                end else begin
                    mem_re = 1'b1;
                    acc_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                end
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (!write_q && !err_q) ? ext_data : 64'd0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= 64'd0;
            acc_q   <= 64'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // The byte-misalignment flag is only consumed when trapping is built in.
    logic unused_ok;
    assign unused_ok = misalign;

endmodule

// File: doc/byte_serial_lsu.md
Name: byte_serial_lsu

Overview:
- Load/store unit sitting directly upstream of the byte-organised data memory, between the EX/MEM pipeline register and the memory array.
- Accepts one load/store request per handshake and sequences it as byte transactions, one byte per cycle, little-endian.
- Assembles load data with sign/zero extension and reports completion to the pipeline, which stalls on busy.

Parameters:
- ADDR_W, 64, address width of requests and memory port.
- MEM_BYTES, 512, size of the byte array; used for the range check.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (N = 1/2/4/8 bytes).
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data; the low N bytes are used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load data, valid with resp_valid.
- resp_err  out  1  access rejected, valid with resp_valid.
- busy  out  1  request in flight (not IDLE).
- mem_addr  out  ADDR_W  byte address to memory.
- mem_wdata  out  8  byte to write.
- mem_we  out  1  byte write strobe.
- mem_re  out  1  byte read strobe.
- mem_rdata  in  8  byte read data; combinational from mem_addr while mem_re is high.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, busy = 0, mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0, byte counter = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, latch write, size, unsigned, addr and wdata; clear the data accumulator.
  - Range check fails (addr + N > MEM_BYTES): go to DONE with the error flag set. No memory access is made.
  - Otherwise go to ACCESS.
- ACCESS:
  - Byte counter i runs 0..N-1; mem_addr = addr + i.
  - Store: mem_we = 1, mem_wdata = wdata[8i+7:8i].
  - Load: mem_re = 1; at the clock edge, mem_rdata is captured into accumulator bits [8i+7:8i].
  - After i = N-1, go to DONE.
  - mem_we/mem_re are 0 in every state other than ACCESS.
- DONE:
  - resp_valid = 1 for exactly one cycle, then return to IDLE.
  - resp_rdata: for loads, accumulator bits [8N-1:0], sign-extended (bit 8N-1) or zero-extended to 64 bits. For stores and errors, resp_rdata = 0.
  - resp_err = error flag.
- Latency: request accepted at edge T; bytes are issued in cycles T+1..T+N; resp_valid is high in cycle T+N+1. The next request can be accepted in cycle T+N+2. Error responses arrive at T+1.
- Alignment: with the feature off, misaligned addresses are legal; bytes are simply issued sequentially.
- Extension:
  - req_unsigned is ignored for stores.
  - For a doubleword load, sign- and zero-extension give identical results.
- Inputs outside IDLE: req_valid and all request fields are ignored while busy. There is no queueing.
- Reset mid-operation: returns to IDLE at the next edge. Remaining bytes are not issued and bytes already written stay in memory. No resp_valid is produced for the aborted request.
- Address arithmetic: addr + N is computed in ADDR_W+1 bits, so an address near 2^64 fails the range check instead of wrapping.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a request whose addr is not a multiple of N completes through DONE with resp_err = 1 at T+1 and makes no memory access. The range check still applies, with the same error response.
- Undefined: misaligned requests are performed byte-serially as normal, with no error.

Decomposition:
- Shared package lsu_pkg holds:
  - Size encodings SZ_B = 0, SZ_H = 1, SZ_W = 2, SZ_D = 3.
  - FSM state encoding.
  - A size-to-byte-count function.
- One sub-module is natural: lsu_extend, a combinational sign/zero extender (64-bit accumulator, size, unsigned → 64-bit result), reused by the writeback mux.

Test Plan:
- Memory preloaded with byte 256 = 0x06, byte 257 = 0x00; load size = 0, unsigned = 0, addr = 256 → resp_rdata = 0x6 at T+2, mem_re high only in cycle T+1.
- Store size = 3, addr = 264, wdata = 0x8877665544332211 → bytes 264..271 = 0x11..0x88 in cycles T+1..T+8, resp_valid at T+9. A follow-up load size = 3 from 264 returns 0x8877665544332211.
- Byte 300 = 0xF0, byte 301 = 0xFF: load size = 1 from 300 signed → 0xFFFFFFFFFFFFFFF0; unsigned → 0x000000000000FFF0.
- Load size = 2 at addr = 510 (510 + 4 > 512) → resp_valid with resp_err = 1 at T+1, mem_re never asserted.
- Reset asserted during byte 3 of a doubleword store to 280 → bytes 280..282 are written, bytes 283..287 are unchanged, no resp_valid, req_ready = 1 the cycle after reset.
- With LSU_MISALIGN_TRAP_EN defined: load size = 2 at addr 258 → resp_err = 1 at T+1, no memory access. Undefined: the same request returns bytes 258..261 assembled, with resp_err = 0.
